usb_fs_out_engine: RTL and testbench
====================================

USB_FS_OUT_ENGINE -- requirements
Module: usb_fs_out_engine

Interface
REQ-001 Parameter NUM_OUT_EPS, default 11, number of OUT endpoints.
REQ-002 Parameter MAX_OUT_PACKET_SIZE, default 32, bytes buffered per endpoint.
REQ-003 One clock; reset is asynchronous and active-high. Ports: clk input 1, rising-edge clock; reset input 1, asynchronous active-high reset.
REQ-004 reset_ep  in  NUM_OUT_EPS  per-endpoint synchronous clear.
REQ-005 dev_addr  in  7  assigned device address.
REQ-006 out_ep_data_avail  out  NUM_OUT_EPS  endpoint holds unread bytes.
REQ-007 out_ep_setup  out  NUM_OUT_EPS  held packet arrived via SETUP.
REQ-008 out_ep_data_get  in  NUM_OUT_EPS  read strobe, one-hot.
REQ-009 out_ep_data  out  8  read byte, valid the cycle after out_ep_data_get.
REQ-010 out_ep_release  in  NUM_OUT_EPS  consumer done with held packet.
REQ-011 out_ep_stall  in  NUM_OUT_EPS  force endpoint to STALL.
REQ-012 out_ep_acked  out  NUM_OUT_EPS  one-cycle pulse when a packet is accepted.
REQ-013 rx_pkt_start, rx_pkt_end, rx_pkt_valid  in  1 each  receiver packet strobes; valid means CRC/PID good at rx_pkt_end.
REQ-014 rx_pid  in  4; rx_addr  in  7; rx_endp  in  4  latest token fields.
REQ-015 rx_data_put  in  1; rx_data  in  8  received payload byte strobe.
REQ-016 tx_pkt_start  out  1  handshake send strobe; tx_pkt_end  in  1; tx_pid  out  4  handshake PID.

Function
REQ-017 Token match: rx_pkt_end & rx_pkt_valid & rx_pid[1:0]==01 & rx_addr==dev_addr & rx_endp<NUM_OUT_EPS; OUT = rx_pid 0001, SETUP = rx_pid 1101.
REQ-018 Endpoint states: READY (buffer empty, accepting), HOLDING (packet owned by consumer), STALL.
REQ-019 Transfer FSM states: IDLE, RCVD_TOKEN, SEND_HS; matched OUT/SETUP in IDLE latches endpoint and setup flag, resets put pointer, -> RCVD_TOKEN.
REQ-020 In RCVD_TOKEN each rx_data_put writes rx_data at put pointer, increments it; bytes beyond MAX_OUT_PACKET_SIZE are dropped and the packet is NAKed.
REQ-021 rx_pkt_end with valid DATA0/DATA1 (rx_pid[1:0]==11) in RCVD_TOKEN -> SEND_HS; invalid packet -> IDLE, no handshake, put pointer rolled back.
REQ-022 rx_pkt_end of a non-DATA packet in RCVD_TOKEN aborts (rollback, no handshake); if it is itself a matched OUT/SETUP, FSM restarts RCVD_TOKEN on the new token.
REQ-023 SEND_HS pulses tx_pkt_start one cycle, -> IDLE; tx_pid priority: SETUP -> ACK (0010) always, endpoint leaves STALL/HOLDING, toggle set to 1 after accept; STALL -> 1110; HOLDING or overflow -> NAK 1010; DATA PID toggle bit != expected -> ACK, data discarded, toggle unchanged; otherwise ACK, toggle inverted, endpoint -> HOLDING.
REQ-024 Accept pulses out_ep_acked[ep] in the SEND_HS cycle; held length = put pointer; zero-length packets accepted with out_ep_data_avail low.
REQ-025 out_ep_data_avail[ep] = HOLDING & get pointer < length; out_ep_data_get while avail increments get pointer; get while not avail is ignored, pointer held.
REQ-026 out_ep_release[ep] in HOLDING -> READY, pointers cleared, out_ep_setup cleared; ignored in other states.
REQ-027 out_ep_stall[ep] -> STALL next cycle, overrides release; only a SETUP exits STALL.
REQ-028 reset_ep[ep] -> READY, toggle 0, pointers 0 next cycle; if ep is the latched transfer endpoint, transfer aborts to IDLE with no handshake.
REQ-029 Buffer is one MAX_OUT_PACKET_SIZE*NUM_OUT_EPS byte RAM, address {endpoint, pointer}; one write, one read port.

Reset
REQ-030 On reset: FSM IDLE, all endpoints READY, toggles 0, pointers 0, out_ep_data 0, tx_pkt_start 0, tx_pid 0, out_ep_acked/avail/setup 0.

Verification
REQ-031 OUT ep1, DATA0 bytes 11 22 33 -> tx_pid 0010, out_ep_acked[1] pulse, avail[1] high, three gets return 11 22 33, avail low.
REQ-032 Second OUT ep1 DATA1 before release -> tx_pid 1010, buffer unchanged; after release, repeat -> ACK.
REQ-033 OUT ep2 DATA1 with expected toggle 0 -> ACK, no acked pulse, avail[2] stays 0.
REQ-034 stall[3] then OUT ep3 -> 1110; SETUP ep3 8 bytes -> ACK, setup[3]=1, next OUT expects DATA1.
REQ-035 OUT ep0 with 33 bytes -> NAK; bad-CRC data -> no tx_pkt_start.
REQ-036 reset asserted mid-packet -> all outputs reset immediately; subsequent OUT ep0 DATA0 ACKed.

Source files
------------

// File: rtl/usb_fs_out_engine_if.sv
// Bundles the endpoint-consumer, token/data receiver and handshake-transmitter signals of the OUT engine.
interface usb_fs_out_engine_if #(
  parameter int NUM_OUT_EPS = 11
);
  logic [NUM_OUT_EPS-1:0] reset_ep;
  logic [6:0]             dev_addr;
  logic [NUM_OUT_EPS-1:0] out_ep_data_avail;
  logic [NUM_OUT_EPS-1:0] out_ep_setup;
  logic [NUM_OUT_EPS-1:0] out_ep_data_get;
  logic [7:0]             out_ep_data;
  logic [NUM_OUT_EPS-1:0] out_ep_release;
  logic [NUM_OUT_EPS-1:0] out_ep_stall;
  logic [NUM_OUT_EPS-1:0] out_ep_acked;
  logic                   rx_pkt_start;
  logic                   rx_pkt_end;
  logic                   rx_pkt_valid;
  logic [3:0]             rx_pid;
  logic [6:0]             rx_addr;
  logic [3:0]             rx_endp;
  logic                   rx_data_put;
  logic [7:0]             rx_data;
  logic                   tx_pkt_start;
  logic                   tx_pkt_end;
  logic [3:0]             tx_pid;

  modport slave (
    input  reset_ep, dev_addr, out_ep_data_get, out_ep_release, out_ep_stall,
    input  rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_pid, rx_addr, rx_endp,
    input  rx_data_put, rx_data, tx_pkt_end,
    output out_ep_data_avail, out_ep_setup, out_ep_data, out_ep_acked,
    output tx_pkt_start, tx_pid
  );

  modport master (
    output reset_ep, dev_addr, out_ep_data_get, out_ep_release, out_ep_stall,
    output rx_pkt_start, rx_pkt_end, rx_pkt_valid, rx_pid, rx_addr, rx_endp,
    output rx_data_put, rx_data, tx_pkt_end,
    input  out_ep_data_avail, out_ep_setup, out_ep_data, out_ep_acked,
    input  tx_pkt_start, tx_pid
  );
endinterface

// File: rtl/usb_fs_out_engine.sv
// USB full-speed OUT/SETUP transfer engine: buffers one packet per endpoint and answers with ACK/NAK/STALL.
// Handshake is issued the cycle after the DATA packet ends; read data follows out_ep_data_get by one cycle.
module usb_fs_out_engine #(
  parameter int NUM_OUT_EPS         = 11,
  parameter int MAX_OUT_PACKET_SIZE = 32
) (
  input logic               clk,
  input logic               reset,
  usb_fs_out_engine_if.slave bus
);
  localparam int EW    = $clog2(NUM_OUT_EPS);
  localparam int AW    = $clog2(MAX_OUT_PACKET_SIZE);
  localparam int CW    = $clog2(MAX_OUT_PACKET_SIZE + 1);
  localparam int DEPTH = NUM_OUT_EPS * MAX_OUT_PACKET_SIZE;
  localparam int RW    = $clog2(DEPTH);

  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_OUT_PACKET_SIZE);
  localparam logic [3:0]    PID_OUT   = 4'b0001;
  localparam logic [3:0]    PID_SETUP = 4'b1101;
  localparam logic [3:0]    PID_ACK   = 4'b0010;
  localparam logic [3:0]    PID_NAK   = 4'b1010;
  localparam logic [3:0]    PID_STALL = 4'b1110;

  typedef enum logic [1:0] {XFER_IDLE, XFER_RCVD_TOKEN, XFER_SEND_HS} xfer_state_t;
  typedef enum logic [1:0] {EP_READY, EP_HOLDING, EP_STALL} ep_state_t;

  xfer_state_t            r_state;
  xfer_state_t            w_state_nxt;
  ep_state_t              r_ep_state [NUM_OUT_EPS];
  logic [NUM_OUT_EPS-1:0] r_tgl;
  logic [NUM_OUT_EPS-1:0] r_setup;
  logic [CW-1:0]          r_len [NUM_OUT_EPS];
  logic [CW-1:0]          r_get [NUM_OUT_EPS];
  logic [EW-1:0]          r_cur_ep;
  logic                   r_cur_setup;
  logic                   r_ovf;
  logic                   r_data_tgl;
  logic [CW-1:0]          r_put_ptr;
  logic [7:0]             r_out_data;
  logic [7:0]             r_mem [DEPTH];

  logic                   w_tok_match;
  logic                   w_is_data;
  logic                   w_cur_rst;
  logic                   w_restart;
  logic                   w_put;
  logic                   w_wr_en;
  logic                   w_hs_go;
  logic                   w_hs_accept;
  logic [3:0]             w_hs_pid;
  logic [NUM_OUT_EPS-1:0] w_acked;
  logic [NUM_OUT_EPS-1:0] w_avail;
  logic                   w_get_vld;
  logic [EW-1:0]          w_get_ep;
  logic [AW-1:0]          w_get_ptr;
  ep_state_t              w_cur_ep_state;

  function automatic logic [RW-1:0] f_addr(input logic [EW-1:0] ep, input logic [AW-1:0] ptr);
    return RW'(ep) * RW'(MAX_OUT_PACKET_SIZE) + RW'(ptr);
  endfunction

  assign w_tok_match = bus.rx_pkt_end && bus.rx_pkt_valid
                    && (bus.rx_pid == PID_OUT || bus.rx_pid == PID_SETUP)
                    && (bus.rx_addr == bus.dev_addr)
                    && (int'(bus.rx_endp) < NUM_OUT_EPS);
  assign w_is_data      = bus.rx_pkt_end && bus.rx_pkt_valid && (bus.rx_pid[1:0] == 2'b11);
  assign w_cur_rst      = bus.reset_ep[r_cur_ep];
  assign w_cur_ep_state = r_ep_state[r_cur_ep];
  assign w_restart      = (r_state == XFER_IDLE && w_tok_match)
                       || (r_state == XFER_RCVD_TOKEN && !w_cur_rst && bus.rx_pkt_end
                           && !w_is_data && w_tok_match);
  assign w_put          = (r_state == XFER_RCVD_TOKEN) && bus.rx_data_put;
  // A held buffer is only overwritten by a SETUP, which always takes ownership back.
  assign w_wr_en        = w_put && (r_put_ptr != MAX_CNT)
                       && (r_cur_setup || w_cur_ep_state == EP_READY);

  always_comb begin
    w_hs_accept = 1'b0;
    w_hs_pid    = PID_ACK;
    if (r_cur_setup) begin
      w_hs_accept = 1'b1;
    end else if (w_cur_ep_state == EP_STALL) begin
      w_hs_pid = PID_STALL;
    end else if (w_cur_ep_state == EP_HOLDING || r_ovf) begin
      w_hs_pid = PID_NAK;
    end else if (r_data_tgl == r_tgl[r_cur_ep]) begin
      w_hs_accept = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hs_go     = 1'b0;
    w_acked     = '0;
    unique case (r_state)
      XFER_IDLE: begin
        if (w_tok_match) w_state_nxt = XFER_RCVD_TOKEN;
      end
      XFER_RCVD_TOKEN: begin
        if (w_cur_rst) begin
          w_state_nxt = XFER_IDLE;
        end else if (bus.rx_pkt_end) begin
          if (w_is_data)        w_state_nxt = XFER_SEND_HS;
          else if (w_tok_match) w_state_nxt = XFER_RCVD_TOKEN;
          else                  w_state_nxt = XFER_IDLE;
        end
      end
      XFER_SEND_HS: begin
        w_state_nxt = XFER_IDLE;
        w_hs_go     = !w_cur_rst;
        if (!w_cur_rst && w_hs_accept) w_acked[r_cur_ep] = 1'b1;
      end
      default: w_state_nxt = XFER_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= XFER_IDLE;
      r_cur_ep    <= '0;
      r_cur_setup <= 1'b0;
      r_ovf       <= 1'b0;
      r_data_tgl  <= 1'b0;
      r_put_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_restart) begin
        r_cur_ep    <= EW'(bus.rx_endp);
        r_cur_setup <= (bus.rx_pid == PID_SETUP);
        r_ovf       <= 1'b0;
        r_put_ptr   <= '0;
      end else if (r_state == XFER_RCVD_TOKEN && w_state_nxt == XFER_IDLE) begin
        r_put_ptr <= '0;
      end else if (w_put) begin
        if (r_put_ptr == MAX_CNT) r_ovf     <= 1'b1;
        else                      r_put_ptr <= r_put_ptr + 1'b1;
      end
      if (r_state == XFER_RCVD_TOKEN && w_is_data) r_data_tgl <= bus.rx_pid[3];
    end
  end

  always_comb begin
    w_avail   = '0;
    w_get_vld = 1'b0;
    w_get_ep  = '0;
    for (int i = 0; i < NUM_OUT_EPS; i++) begin
      w_avail[i] = (r_ep_state[i] == EP_HOLDING) && (r_get[i] < r_len[i]);
      if (bus.out_ep_data_get[i] && w_avail[i]) begin
        w_get_vld = 1'b1;
        w_get_ep  = EW'(i);
      end
    end
    w_get_ptr = r_get[w_get_ep][AW-1:0];
  end

  // Later assignments win: handshake, then get/release, then stall, then per-endpoint reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tgl   <= '0;
      r_setup <= '0;
      for (int i = 0; i < NUM_OUT_EPS; i++) begin
        r_ep_state[i] <= EP_READY;
        r_len[i]      <= '0;
        r_get[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT_EPS; i++) begin
        if (w_acked[i]) begin
          r_ep_state[i] <= EP_HOLDING;
          r_len[i]      <= r_put_ptr;
          r_get[i]      <= '0;
          r_setup[i]    <= r_cur_setup;
          r_tgl[i]      <= r_cur_setup ? 1'b1 : ~r_tgl[i];
        end
        if (bus.out_ep_data_get[i] && w_avail[i]) r_get[i] <= r_get[i] + 1'b1;
        if (bus.out_ep_release[i] && r_ep_state[i] == EP_HOLDING) begin
          r_ep_state[i] <= EP_READY;
          r_len[i]      <= '0;
          r_get[i]      <= '0;
          r_setup[i]    <= 1'b0;
        end
        if (bus.out_ep_stall[i]) r_ep_state[i] <= EP_STALL;
        if (bus.reset_ep[i]) begin
          r_ep_state[i] <= EP_READY;
          r_tgl[i]      <= 1'b0;
          r_len[i]      <= '0;
          r_get[i]      <= '0;
          r_setup[i]    <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[f_addr(r_cur_ep, r_put_ptr[AW-1:0])] <= bus.rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_out_data <= '0;
    else if (w_get_vld) r_out_data <= r_mem[f_addr(w_get_ep, w_get_ptr)];
  end

  assign bus.out_ep_data_avail = w_avail;
  assign bus.out_ep_setup      = r_setup;
  assign bus.out_ep_data       = r_out_data;
  assign bus.out_ep_acked      = w_acked;
  assign bus.tx_pkt_start      = w_hs_go;
  assign bus.tx_pid            = w_hs_go ? w_hs_pid : 4'b0000;
endmodule

// File: tb/tb_usb_fs_out_engine.sv
// Directed bench for usb_fs_out_engine; a monitor pops expected handshakes and read bytes from queues.
module tb_usb_fs_out_engine;
  localparam int NEP  = 11;
  localparam int MAXP = 32;
  localparam logic [6:0] DEV = 7'd5;
  localparam logic [3:0] OUT = 4'b0001, SETUP = 4'b1101, DATA0 = 4'b0011, DATA1 = 4'b1011;
  localparam logic [3:0] ACK = 4'b0010, NAK = 4'b1010, STALL = 4'b1110;

  typedef struct packed {
    logic [3:0]     pid;
    logic [NEP-1:0] acked;
  } hs_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  usb_fs_out_engine_if #(.NUM_OUT_EPS(NEP)) bus();
  usb_fs_out_engine #(.NUM_OUT_EPS(NEP), .MAX_OUT_PACKET_SIZE(MAXP)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  hs_t        hs_q[$];
  logic [7:0] rd_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic       rd_pend     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    hs_t        e;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        d = rd_q.pop_front();
        chk("read_byte", 32'(bus.out_ep_data), 32'(d));
      end
      rd_pend = |bus.out_ep_data_get;
      if (bus.tx_pkt_start) begin
        if (hs_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_handshake: got pid %b, expected none", bus.tx_pid);
        end else begin
          e = hs_q.pop_front();
          chk("hs_pid", 32'(bus.tx_pid), 32'(e.pid));
          chk("hs_acked", 32'(bus.out_ep_acked), 32'(e.acked));
        end
      end else if (|bus.out_ep_acked) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_acked: got %b, expected 0", bus.out_ep_acked);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_hs(input logic [3:0] pid, input int ep);
    hs_t e;
    e.pid   = pid;
    e.acked = (ep < 0) ? '0 : (NEP'(1) << ep);
    hs_q.push_back(e);
  endtask

  task automatic token(input logic [3:0] pid, input int ep);
    bus.rx_pid       = pid;
    bus.rx_addr      = DEV;
    bus.rx_endp      = 4'(ep);
    bus.rx_pkt_start = 1'b1;
    tick();
    bus.rx_pkt_start = 1'b0;
    bus.rx_pkt_end   = 1'b1;
    bus.rx_pkt_valid = 1'b1;
    tick();
    bus.rx_pkt_end   = 1'b0;
    bus.rx_pkt_valid = 1'b0;
  endtask

  task automatic data_pkt(input logic [3:0] pid, input int n, input logic [7:0] seed, input logic good);
    bus.rx_pid       = pid;
    bus.rx_pkt_start = 1'b1;
    tick();
    bus.rx_pkt_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.rx_data_put = 1'b1;
      bus.rx_data     = seed + 8'(i * 17);
      tick();
    end
    bus.rx_data_put  = 1'b0;
    bus.rx_pkt_end   = 1'b1;
    bus.rx_pkt_valid = good;
    tick();
    bus.rx_pkt_end   = 1'b0;
    bus.rx_pkt_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic read_bytes(input int ep, input int n, input logic [7:0] seed);
    for (int i = 0; i < n; i++) begin
      rd_q.push_back(seed + 8'(i * 17));
      bus.out_ep_data_get = NEP'(1) << ep;
      tick();
    end
    bus.out_ep_data_get = '0;
    repeat (2) tick();
  endtask

  task automatic pulse_release(input int ep);
    bus.out_ep_release = NEP'(1) << ep;
    tick();
    bus.out_ep_release = '0;
  endtask

  task automatic pulse_stall(input int ep);
    bus.out_ep_stall = NEP'(1) << ep;
    tick();
    bus.out_ep_stall = '0;
  endtask

  task automatic pulse_reset_ep(input int ep);
    bus.reset_ep = NEP'(1) << ep;
    tick();
    bus.reset_ep = '0;
  endtask

  task automatic chk_outputs_reset(input string tag);
    chk({tag, "_avail"}, 32'(bus.out_ep_data_avail), 0);
    chk({tag, "_setup"}, 32'(bus.out_ep_setup), 0);
    chk({tag, "_acked"}, 32'(bus.out_ep_acked), 0);
    chk({tag, "_data"}, 32'(bus.out_ep_data), 0);
    chk({tag, "_txstart"}, 32'(bus.tx_pkt_start), 0);
    chk({tag, "_txpid"}, 32'(bus.tx_pid), 0);
  endtask

  initial begin
    bus.reset_ep        = '0;
    bus.dev_addr        = DEV;
    bus.out_ep_data_get = '0;
    bus.out_ep_release  = '0;
    bus.out_ep_stall    = '0;
    bus.rx_pkt_start    = 1'b0;
    bus.rx_pkt_end      = 1'b0;
    bus.rx_pkt_valid    = 1'b0;
    bus.rx_pid          = '0;
    bus.rx_addr         = '0;
    bus.rx_endp         = '0;
    bus.rx_data_put     = 1'b0;
    bus.rx_data         = '0;
    bus.tx_pkt_end      = 1'b0;
    repeat (3) tick();
    chk_outputs_reset("por");
    reset = 1'b0;
    repeat (2) tick();

    // OUT ep1 DATA0 11 22 33; a second OUT before release is NAKed and leaves the buffer alone.
    expect_hs(ACK, 1);
    token(OUT, 1); data_pkt(DATA0, 3, 8'h11, 1'b1);
    chk("ep1_avail_after_ack", 32'(bus.out_ep_data_avail[1]), 1);
    expect_hs(NAK, -1);
    token(OUT, 1); data_pkt(DATA1, 2, 8'hA0, 1'b1);
    read_bytes(1, 3, 8'h11);
    chk("ep1_avail_drained", 32'(bus.out_ep_data_avail[1]), 0);
    pulse_release(1);
    expect_hs(ACK, 1);
    token(OUT, 1); data_pkt(DATA1, 2, 8'hA0, 1'b1);
    read_bytes(1, 2, 8'hA0);
    pulse_release(1);

    // Toggle mismatch on ep2: ACK but no data kept.
    expect_hs(ACK, -1);
    token(OUT, 2); data_pkt(DATA1, 2, 8'h40, 1'b1);
    chk("ep2_avail_dup", 32'(bus.out_ep_data_avail[2]), 0);

    // STALL on ep3, cleared by SETUP, then DATA1 is the expected toggle.
    pulse_stall(3);
    expect_hs(STALL, -1);
    token(OUT, 3); data_pkt(DATA0, 1, 8'h01, 1'b1);
    expect_hs(ACK, 3);
    token(SETUP, 3); data_pkt(DATA0, 8, 8'h80, 1'b1);
    chk("ep3_setup_flag", 32'(bus.out_ep_setup), 32'(NEP'(1) << 3));
    read_bytes(3, 8, 8'h80);
    chk("ep3_avail_drained", 32'(bus.out_ep_data_avail[3]), 0);
    pulse_release(3);
    chk("ep3_setup_cleared", 32'(bus.out_ep_setup[3]), 0);
    expect_hs(ACK, -1);
    token(OUT, 3); data_pkt(DATA0, 1, 8'h02, 1'b1);
    chk("ep3_avail_data0_dropped", 32'(bus.out_ep_data_avail[3]), 0);
    expect_hs(ACK, 3);
    token(OUT, 3); data_pkt(DATA1, 1, 8'h03, 1'b1);
    chk("ep3_avail_data1", 32'(bus.out_ep_data_avail[3]), 1);
    pulse_release(3);

    // Overflow NAK, bad CRC silent, then a good packet and a full-size packet on ep0.
    expect_hs(NAK, -1);
    token(OUT, 0); data_pkt(DATA0, 33, 8'h00, 1'b1);
    chk("ep0_avail_ovf", 32'(bus.out_ep_data_avail[0]), 0);
    token(OUT, 0); data_pkt(DATA0, 4, 8'h10, 1'b0);
    expect_hs(ACK, 0);
    token(OUT, 0); data_pkt(DATA0, 2, 8'h55, 1'b1);
    read_bytes(0, 2, 8'h55);
    pulse_release(0);
    expect_hs(ACK, 0);
    token(OUT, 0); data_pkt(DATA1, 32, 8'h07, 1'b1);
    chk("ep0_avail_full", 32'(bus.out_ep_data_avail[0]), 1);
    pulse_release(0);

    // Per-endpoint reset clears holding state and toggle, and aborts an in-flight transfer.
    expect_hs(ACK, 2);
    token(OUT, 2); data_pkt(DATA0, 1, 8'h66, 1'b1);
    chk("ep2_avail_held", 32'(bus.out_ep_data_avail[2]), 1);
    pulse_reset_ep(2);
    chk("ep2_avail_reset", 32'(bus.out_ep_data_avail[2]), 0);
    expect_hs(ACK, 2);
    token(OUT, 2); data_pkt(DATA0, 1, 8'h67, 1'b1);
    pulse_reset_ep(2);
    token(OUT, 4);
    bus.rx_pid = DATA0; bus.rx_pkt_start = 1'b1; tick(); bus.rx_pkt_start = 1'b0;
    bus.rx_data_put = 1'b1; bus.rx_data = 8'h99; tick();
    bus.rx_data_put = 1'b0; pulse_reset_ep(4);
    bus.rx_pkt_end = 1'b1; bus.rx_pkt_valid = 1'b1; tick();
    bus.rx_pkt_end = 1'b0; bus.rx_pkt_valid = 1'b0;
    repeat (3) tick();

    // Global reset in the middle of a packet while ep1 holds data.
    expect_hs(ACK, 1);
    token(OUT, 1); data_pkt(DATA0, 1, 8'h5A, 1'b1);
    chk("ep1_avail_prereset", 32'(bus.out_ep_data_avail[1]), 1);
    read_bytes(1, 1, 8'h5A);
    token(OUT, 0);
    bus.rx_pid = DATA0; bus.rx_pkt_start = 1'b1; tick(); bus.rx_pkt_start = 1'b0;
    bus.rx_data_put = 1'b1; bus.rx_data = 8'hC3; tick();
    #2 reset = 1'b1;
    #1 chk_outputs_reset("async");
    bus.rx_data_put = 1'b0;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    expect_hs(ACK, 0);
    token(OUT, 0); data_pkt(DATA0, 2, 8'h21, 1'b1);
    read_bytes(0, 2, 8'h21);

    for (int i = 0; i < 50 && (hs_q.size() != 0 || rd_q.size() != 0); i++) tick();
    chk("hs_queue_drained", 32'(hs_q.size()), 0);
    chk("rd_queue_drained", 32'(rd_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
